mmio_bus_ctrl: RTL and testbench
================================

// Module: mmio_bus_ctrl
// PURPOSE
//   Memory-mapped bus controller between the cpu memory port and the on-chip RAM plus IO registers.
//   Generalises the switch/LED decode to NOUT output registers and NIN input ports.
//   Adds a handshaked access FSM with configurable RAM read latency and a 2-flop synchroniser per input.
//   Adds sticky input-change flags and a bus-error flag, readable through a status register.
// PARAMETERS
//   DW          16      data width of bus, RAM and every IO port
//   AW          9       bus address width; mem_addr[AW-1]=0 selects RAM, =1 selects IO
//   NOUT        2       number of output registers (1..16)
//   NIN         2       number of input ports (1..DW-1)
//   RAM_LAT     1       RAM read latency in cycles (>=1)
//   OUT_BASE    9'h100  address of output register 0; register i at OUT_BASE+i
//   IN_BASE     9'h140  address of input port 0; port i at IN_BASE+i
//   STATUS_ADDR 9'h180  address of status register
//   OUT_RESET   0       reset value of every output register
// PORTS
//   clk        in   1        single clock, rising edge
//   reset      in   1        asynchronous, active-high
//   mem_cmd    in   2        2'b00 none, 2'b01 read, 2'b10 write, 2'b11 illegal
//   mem_addr   in   AW       bus address
//   write_data in   DW       write data
//   read_data  out  DW       registered read data; holds until the next read completes
//   mem_ready  out  1        one-cycle pulse: access complete
//   ram_addr   out  AW-1     RAM address (latched bus address)
//   ram_write  out  1        RAM write enable
//   ram_din    out  DW       RAM write data (latched)
//   ram_dout   in   DW       RAM read data
//   out_port   out  NOUT*DW  output registers; register i at [i*DW +: DW]
//   in_port    in   NIN*DW   asynchronous inputs; port i at [i*DW +: DW]
// BEHAVIOUR
//   Reset: state IDLE; read_data=0; mem_ready=0; ram_write=0; out_port all OUT_RESET;
//     synchronisers, change flags and error flag all 0. Reset mid-access aborts the access.
//     An aborted access performs no RAM write and no register update.
//   FSM IDLE/WAIT/RESP. In IDLE, a cmd of 01 or 10 latches cmd, addr and data on the clock edge.
//     Cycle 0 is the cycle the cmd is first seen.
//   IO access: IDLE->RESP. The register write or read_data load occurs on the cycle-0 edge.
//     mem_ready is high in cycle 1.
//   RAM access: IDLE->WAIT for RAM_LAT cycles (cycles 1..RAM_LAT), then ->RESP.
//     mem_ready is high in cycle RAM_LAT+1.
//   RAM write: ram_write is high in cycle 1 only.
//   RAM read: ram_dout is sampled into read_data at the end of cycle RAM_LAT.
//   RESP->IDLE always. A cmd present in the IDLE cycle after RESP starts a new access,
//     so the cpu drops cmd after mem_ready.
//   cmd 11 in IDLE: no access, no mem_ready, error flag set.
//   Inputs: each port passes through a 2-flop synchroniser (s2). change[i] sets when s2[i] differs
//     from its previous-cycle value.
//   Status read: returns {err, 0..., change[NIN-1:0]} and clears err and all change flags.
//     A same-cycle set wins over the clear.
//   IO read map: OUT_BASE+i -> out reg i; IN_BASE+i -> s2[i]; STATUS_ADDR -> status.
//   IO write map: OUT_BASE+i loads write_data. Writes to IN or STATUS addresses are ignored, no error.
//   Any other IO address: read returns 0, writes are ignored, err sets. mem_ready still pulses.
//   Widths: ram_addr = mem_addr[AW-2:0]; no arithmetic wrap (index = addr-BASE, range-checked).
// TESTING
//   RAM write h0005<-h1234, then read h0005 (RAM_LAT=1) -> ram_write is high 1 cycle;
//     mem_ready is high in cycle 2; read_data = h1234.
//   RAM_LAT=3 read -> mem_ready is high exactly in cycle 4 and never earlier; read_data = ram_dout.
//   Write h00A5 to h100, then read h100 -> out_port[15:0] = h00A5 after the cycle-0 edge;
//     mem_ready is high in cycle 1; read returns h00A5.
//   in_port[15:0]=h0003 after reset -> read h140 returns h0003 from 2 cycles after the change;
//     status reads h0001; an immediate second status read returns h0000.
//   Read h1C0 (unmapped) -> read_data = 0, mem_ready pulses, status bit15 = 1; cmd 11 also sets bit15.
//   Assert reset during WAIT of a RAM write -> no ram_write pulse, no mem_ready;
//     all outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: routes cpu accesses to on-chip RAM or IO registers,
// synchronises asynchronous input ports and reports change/error flags via a status register.
module mmio_bus_ctrl #(
    parameter int              DW          = 16,
    parameter int              AW          = 9,
    parameter int              NOUT        = 2,
    parameter int              NIN         = 2,
    parameter int              RAM_LAT     = 1,
    parameter int              OUT_BASE    = 'h100,
    parameter int              IN_BASE     = 'h140,
    parameter int              STATUS_ADDR = 'h180,
    parameter logic [DW-1:0]   OUT_RESET   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mem_cmd,
    input  logic [AW-1:0]       mem_addr,
    input  logic [DW-1:0]       write_data,
    output logic [DW-1:0]       read_data,
    output logic                mem_ready,
    output logic [AW-2:0]       ram_addr,
    output logic                ram_write,
    output logic [DW-1:0]       ram_din,
    input  logic [DW-1:0]       ram_dout,
    output logic [NOUT*DW-1:0]  out_port,
    input  logic [NIN*DW-1:0]   in_port
);

    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;
    localparam int OIW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int IIW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int CW  = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    logic            r_is_rd;
    logic [AW-2:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_read_data;
    logic            r_mem_ready;
    logic            r_ram_write;
    logic [DW-1:0]   r_out  [NOUT];
    logic [DW-1:0]   r_s1   [NIN];
    logic [DW-1:0]   r_s2   [NIN];
    logic [DW-1:0]   r_s2_d [NIN];
    logic [NIN-1:0]  r_chg;
    logic            r_err;

    logic [31:0]     w_addr32;
    logic            w_out_hit;
    logic            w_in_hit;
    logic            w_stat_hit;
    logic [OIW-1:0]  w_out_idx;
    logic [IIW-1:0]  w_in_idx;
    logic [DW-1:0]   w_status;
    logic [DW-1:0]   w_io_rdata;
    logic            w_acc;
    logic            w_io;
    logic [NIN-1:0]  w_chg_set;
    logic            w_err_set;
    logic            w_stat_clr;

    assign w_addr32   = 32'(mem_addr);
    assign w_out_hit  = (w_addr32 >= 32'(OUT_BASE)) && (w_addr32 < 32'(OUT_BASE + NOUT));
    assign w_in_hit   = (w_addr32 >= 32'(IN_BASE)) && (w_addr32 < 32'(IN_BASE + NIN));
    assign w_stat_hit = (w_addr32 == 32'(STATUS_ADDR));
    assign w_out_idx  = OIW'(w_addr32 - 32'(OUT_BASE));
    assign w_in_idx   = IIW'(w_addr32 - 32'(IN_BASE));
    assign w_acc      = (mem_cmd == CMD_RD) || (mem_cmd == CMD_WR);
    assign w_io       = mem_addr[AW-1];

    always_comb begin
        w_status = '0;
        w_status[DW-1] = r_err;
        w_status[NIN-1:0] = r_chg;
    end

    always_comb begin
        w_io_rdata = '0;
        if (w_out_hit)
            w_io_rdata = r_out[w_out_idx];
        else if (w_in_hit)
            w_io_rdata = r_s2[w_in_idx];
        else if (w_stat_hit)
            w_io_rdata = w_status;
    end

    always_comb begin
        for (int i = 0; i < NIN; i++)
            w_chg_set[i] = (r_s2[i] != r_s2_d[i]);
    end

    assign w_err_set  = (r_state == S_IDLE) &&
                        ((mem_cmd == CMD_ILL) ||
                         (w_acc && w_io && !(w_out_hit || w_in_hit || w_stat_hit)));
    assign w_stat_clr = (r_state == S_IDLE) && (mem_cmd == CMD_RD) && w_io && w_stat_hit;

    // Access FSM; IO accesses complete at the cycle-0 edge, RAM accesses count RAM_LAT wait cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_is_rd     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_read_data <= '0;
            r_mem_ready <= 1'b0;
            r_ram_write <= 1'b0;
            for (int i = 0; i < NOUT; i++)
                r_out[i] <= OUT_RESET;
        end else begin
            r_mem_ready <= 1'b0;
            r_ram_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_is_rd <= (mem_cmd == CMD_RD);
                        r_addr  <= mem_addr[AW-2:0];
                        r_wdata <= write_data;
                        if (w_io) begin
                            if (mem_cmd == CMD_RD)
                                r_read_data <= w_io_rdata;
                            else if (w_out_hit)
                                r_out[w_out_idx] <= write_data;
                            r_mem_ready <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_ram_write <= (mem_cmd == CMD_WR);
                            r_cnt       <= CW'(RAM_LAT - 1);
                            r_state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_is_rd)
                            r_read_data <= ram_dout;
                        r_mem_ready <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A flag set in the same cycle as a status read survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NIN; i++) begin
                r_s1[i]   <= '0;
                r_s2[i]   <= '0;
                r_s2_d[i] <= '0;
            end
            r_chg <= '0;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                r_s1[i]   <= in_port[i*DW +: DW];
                r_s2[i]   <= r_s1[i];
                r_s2_d[i] <= r_s2[i];
            end
            r_chg <= w_stat_clr ? w_chg_set : (r_chg | w_chg_set);
            r_err <= w_stat_clr ? w_err_set : (r_err | w_err_set);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NOUT; g++) begin : g_out
            assign out_port[g*DW +: DW] = r_out[g];
        end
    endgenerate

    assign read_data = r_read_data;
    assign mem_ready = r_mem_ready;
    assign ram_write = r_ram_write;
    assign ram_addr  = r_addr;
    assign ram_din   = r_wdata;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Scoreboard bench for mmio_bus_ctrl: directed accesses push expectations, a monitor checks
// every mem_ready pulse; a second instance exercises a longer RAM latency.
module tb_mmio_bus_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   mem_cmd, cmd3;
    logic [8:0]   mem_addr;
    logic [15:0]  write_data;
    logic [15:0]  read_data, read_data3;
    logic         mem_ready, mem_ready3;
    logic [7:0]   ram_addr, ram_addr3;
    logic         ram_write, ram_write3;
    logic [15:0]  ram_din, ram_din3;
    logic [15:0]  ram_dout, ram_dout3;
    logic [31:0]  out_port, out_port3;
    logic [31:0]  in_port;

    logic [15:0]  mem [0:255];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int           wr_pulses = 0;

    typedef struct {
        logic [15:0] data;
        logic        chk;
        int          lat;
        int          issue;
        string       name;
    } exp_t;
    exp_t q[$];

    mmio_bus_ctrl #(.RAM_LAT(1)) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data), .mem_ready(mem_ready),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
        .ram_dout(ram_dout), .out_port(out_port), .in_port(in_port)
    );

    mmio_bus_ctrl #(.RAM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .mem_cmd(cmd3), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data3), .mem_ready(mem_ready3),
        .ram_addr(ram_addr3), .ram_write(ram_write3), .ram_din(ram_din3),
        .ram_dout(ram_dout3), .out_port(out_port3), .in_port(in_port)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    always @(posedge clk) if (ram_write) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    always @(negedge clk) if (ram_write) wr_pulses++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && mem_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_mem_ready", 32'(mem_ready), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
                if (e.chk)
                    chk({e.name, "_rdata"}, 32'(read_data), 32'(e.data));
            end
        end
    end

    task automatic access(input logic [1:0] c, input logic [8:0] a, input logic [15:0] wd,
                          input logic ck, input logic [15:0] ed, input int lat, input string nm);
        int n;
        exp_t e;
        @(negedge clk);
        mem_cmd = c; mem_addr = a; write_data = wd;
        e.data = ed; e.chk = ck; e.lat = lat; e.issue = cyc; e.name = nm;
        q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 20);
        if (!mem_ready) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            q.delete();
        end
        mem_cmd = 2'b00;
    endtask

    initial begin
        reset = 1'b1; mem_cmd = 2'b00; cmd3 = 2'b00; mem_addr = '0;
        write_data = '0; in_port = '0; ram_dout3 = 16'h1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_data", 32'(read_data), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_ram_write", 32'(ram_write), 32'd0);
        chk("rst_out_port", out_port, 32'd0);
        reset = 1'b0;

        access(2'b10, 9'h005, 16'h1234, 1'b0, 16'h0, 2, "ram_wr");
        chk("ram_wr_pulses", 32'(wr_pulses), 32'd1);
        chk("ram_mem_written", 32'(mem[5]), 32'h1234);
        access(2'b01, 9'h005, 16'h0, 1'b1, 16'h1234, 2, "ram_rd");

        access(2'b10, 9'h100, 16'h00A5, 1'b0, 16'h0, 1, "out0_wr");
        chk("out0_value", 32'(out_port[15:0]), 32'h00A5);
        access(2'b10, 9'h101, 16'h5A5A, 1'b0, 16'h0, 1, "out1_wr");
        chk("out1_value", 32'(out_port[31:16]), 32'h5A5A);
        access(2'b01, 9'h100, 16'h0, 1'b1, 16'h00A5, 1, "out0_rd");
        access(2'b01, 9'h101, 16'h0, 1'b1, 16'h5A5A, 1, "out1_rd");
        access(2'b10, 9'h140, 16'hFFFF, 1'b0, 16'h0, 1, "in_wr_ignored");

        in_port[15:0] = 16'h0003;
        access(2'b01, 9'h140, 16'h0, 1'b1, 16'h0000, 1, "in0_rd_early");
        access(2'b01, 9'h140, 16'h0, 1'b1, 16'h0003, 1, "in0_rd_sync");
        access(2'b01, 9'h141, 16'h0, 1'b1, 16'h0000, 1, "in1_rd");
        access(2'b01, 9'h180, 16'h0, 1'b1, 16'h0001, 1, "status_chg");
        access(2'b01, 9'h180, 16'h0, 1'b1, 16'h0000, 1, "status_clr");

        access(2'b01, 9'h1C0, 16'h0, 1'b1, 16'h0000, 1, "unmapped_rd");
        access(2'b01, 9'h180, 16'h0, 1'b1, 16'h8000, 1, "status_err_unmapped");

        @(negedge clk); mem_cmd = 2'b11;
        @(negedge clk); mem_cmd = 2'b00;
        repeat (3) @(negedge clk);
        access(2'b01, 9'h180, 16'h0, 1'b1, 16'h8000, 1, "status_err_illegal");
        access(2'b01, 9'h180, 16'h0, 1'b1, 16'h0000, 1, "status_err_clr");

        // Longer RAM latency: read_data must capture ram_dout at the end of cycle 3 only.
        @(negedge clk);
        cmd3 = 2'b01; mem_addr = 9'h010; ram_dout3 = 16'h1111;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("lat3_ready_c%0d", k), 32'(mem_ready3), 32'(k == 4));
            ram_dout3 = (k == 3) ? 16'h2222 : ((k >= 4) ? 16'h3333 : 16'h1111);
            if (k == 4) cmd3 = 2'b00;
        end
        chk("lat3_rdata", 32'(read_data3), 32'h2222);

        // Abort a RAM write mid-access with an asynchronous reset.
        @(negedge clk);
        mem_cmd = 2'b10; mem_addr = 9'h007; write_data = 16'h5555;
        @(posedge clk);
        #1;
        chk("abort_ram_write_started", 32'(ram_write), 32'd1);
        reset = 1'b1;
        #1;
        mem_cmd = 2'b00;
        chk("abort_ram_write", 32'(ram_write), 32'd0);
        chk("abort_mem_ready", 32'(mem_ready), 32'd0);
        chk("abort_out_port", out_port, 32'd0);
        chk("abort_read_data3", 32'(read_data3), 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(mem_ready), 32'd0);
        end
        chk("abort_no_write_pulse", 32'(wr_pulses), 32'd1);
        chk("abort_mem_untouched", 32'(mem[7]), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
